shift_univ_reg_n: RTL and testbench
===================================

Name: shift_univ_reg_n

Overview:
- Parametrised N-bit universal shift register; next generation of the team's N-bit right shift register.
- Adds bidirectional shift, rotate, arithmetic shift right and parallel load.
- Adds a counted burst mode: a start pulse shifts K positions autonomously, reporting busy/done.
- Used as a serialiser/deserialiser and bit-alignment stage in datapath exercises.

Parameters:
- N, 8, register width in bits (N >= 2).
- CW, $clog2(N+1), width of the burst count port.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; 0 freezes register, counter and FSM.
- mode  in  3  operation select (see Behaviour).
- d  in  N  parallel load data.
- sil  in  1  serial in at MSB side, used by SHR.
- sir  in  1  serial in at LSB side, used by SHL.
- start  in  1  begin a burst of cnt shifts in the current mode.
- cnt  in  CW  burst length, sampled with start.
- q  out  N  register contents.
- sor  out  1  right serial out = q[0], combinational.
- sol  out  1  left serial out = q[N-1], combinational.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after burst completes.

Behaviour:
- Reset: rst=1 at a clk edge overrides everything, including en and a burst in progress. It sets q=0, busy=0, done=0, FSM=IDLE and remaining count=0.
- Mode encoding:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q<=d.
  - 010 SHR: q<={sil,q[N-1:1]}.
  - 011 SHL: q<={q[N-2:0],sir}.
  - 100 ROR: q<={q[0],q[N-1:1]}.
  - 101 ROL: q<={q[N-2:0],q[N-1]}.
  - 110 ASR: q<={q[N-1],q[N-1:1]}.
  - 111: reserved, behaves as HOLD.
- IDLE, start=0, en=1: one operation per edge per mode; latency 1 cycle (q reflects the op after the edge).
- IDLE, start=1, en=1, shift mode (010..110), cnt>0:
  - Latch mode into mode_r and cnt into rem; go to RUN; busy=1.
  - No shift on the accepting edge.
- RUN, en=1, each edge:
  - Apply one mode_r operation; sil/sir are sampled live each edge.
  - rem<=rem-1.
  - When rem transitions 1->0: go to IDLE, busy<=0, done<=1 for exactly one cycle.
  - Net effect: cnt=K gives busy high K cycles, final q after edge K+1 counted from the accepting edge, done high during the cycle following that edge.
- RUN inputs: mode, d, start and cnt are ignored. A start during RUN is dropped, not queued.
- en=0: q, rem, FSM and busy hold. done is always a single-cycle pulse and clears on the next edge regardless of en.
- start=1 with cnt=0, or with a non-shift mode (000, 001, 111):
  - No RUN.
  - Non-shift modes perform their normal single op.
  - done pulses the next cycle.
  - busy stays 0.
- cnt > N is legal: shifts continue, rotations wrap modulo N, SHR/SHL fill completely with serial input, ASR saturates to all sign bits.
- Mid-burst rst: abort, all state cleared as above, no done pulse.
- sor/sol always track q combinationally; no extra latency.

Decomposition:
- Package shift_univ_pkg: 3-bit mode constants (MODE_HOLD..MODE_RSVD), FSM state encoding (ST_IDLE, ST_RUN), helper function is_shift_mode.
- Sub-module shift_univ_next: purely combinational next-value mux (q, mode, d, sil, sir) -> q_next.
  - Instantiated once.
  - Shared by direct and burst paths.
  - Top level owns the registers, rem counter and FSM.

Test Plan (N=8):
- rst=1 for 2 edges with en=1, mode=LOAD, d=8'hFF -> q=8'h00, busy=0, done=0. rst low, LOAD 8'hA5 -> q=8'hA5 next cycle, sor=1, sol=1.
- From q=8'hA5: SHR with sil=1 -> 8'hD2. SHL with sir=1 -> 8'hA5. ROL from 8'h81 -> 8'h03. ROR from 8'h81 -> 8'hC0.
- q=8'h80, start=1, mode=ASR, cnt=3:
  - busy high for exactly 3 cycles.
  - q goes 8'hC0, 8'hE0, 8'hF0.
  - done one cycle after busy falls.
  - mode changed to LOAD during RUN has no effect.
- Burst SHR cnt=4 from 8'h00, sil=1, en=0 for 2 cycles mid-burst:
  - q and busy freeze while en=0.
  - Final q=8'hF0.
  - busy high 6 cycles total.
- rst asserted on the 2nd RUN cycle of a cnt=5 ROL burst -> q=0, busy=0, no done pulse. A new start after reset is accepted normally.
- Edge cases:
  - start with cnt=0 -> done pulse next cycle, q unchanged, busy=0.
  - Mode 111 with en=1 -> q holds.
  - cnt=9 ROR burst from 8'h01 -> q=8'h80 (wrap past N).

Source files
------------

// File: rtl/shift_univ_reg_n_pkg.sv
// Shared constants, FSM encoding and mode helpers for the universal shift register.
package shift_univ_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Only the positional modes may run a counted burst.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
    return (m >= MODE_SHR) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_univ_reg_n_if.sv
// Control/data bundle between a driver (master) and the shift register (slave).
interface shift_univ_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
);
  import shift_univ_pkg::*;

  logic              en;
  logic [MODE_W-1:0] mode;
  logic [N-1:0]      d;
  logic              sil;
  logic              sir;
  logic              start;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      q;
  logic              sor;
  logic              sol;
  logic              busy;
  logic              done;

  modport master (
    output en, mode, d, sil, sir, start, cnt,
    input  q, sor, sol, busy, done
  );

  modport slave (
    input  en, mode, d, sil, sir, start, cnt,
    output q, sor, sol, busy, done
  );

endinterface

// File: rtl/shift_univ_reg_n_next.sv
// Combinational next-value mux shared by single-op and burst paths.
module shift_univ_next
  import shift_univ_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]      q,
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      d,
  input  logic              sil,
  input  logic              sir,
  output logic [N-1:0]      q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_LOAD: q_next = d;
      MODE_SHR:  q_next = {sil, q[N-1:1]};
      MODE_SHL:  q_next = {q[N-2:0], sir};
      MODE_ROR:  q_next = {q[0], q[N-1:1]};
      MODE_ROL:  q_next = {q[N-2:0], q[N-1]};
      MODE_ASR:  q_next = {q[N-1], q[N-1:1]};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_univ_reg_n.sv
// N-bit universal shift register with single-op and counted burst operation.
module shift_univ_reg_n
  import shift_univ_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  shift_univ_if.slave  bus
);

  state_t            state_q, state_d;
  logic [N-1:0]      q_q, q_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [MODE_W-1:0] mode_r_q, mode_r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [MODE_W-1:0] sel_mode;
  logic [N-1:0]      q_nxt;

  // A running burst uses its latched mode; idle ops use the live mode.
  assign sel_mode = (state_q == ST_RUN) ? mode_r_q : bus.mode;

  shift_univ_next #(.N(N)) u_next (
    .q      (q_q),
    .mode   (sel_mode),
    .d      (bus.d),
    .sil    (bus.sil),
    .sir    (bus.sir),
    .q_next (q_nxt)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    rem_d    = rem_q;
    mode_r_d = mode_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (bus.en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_shift_mode(bus.mode) && (bus.cnt != '0)) begin
              mode_r_d = bus.mode;
              rem_d    = bus.cnt;
              state_d  = ST_RUN;
              busy_d   = 1'b1;
            end else begin
              // Degenerate start: report completion, shift modes do not move.
              done_d = 1'b1;
              if (!is_shift_mode(bus.mode)) q_d = q_nxt;
            end
          end else begin
            q_d = q_nxt;
          end
        end
        ST_RUN: begin
          q_d   = q_nxt;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      rem_q    <= '0;
      mode_r_q <= MODE_HOLD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      mode_r_q <= mode_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.sor  = q_q[0];
  assign bus.sol  = q_q[N-1];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_univ_reg_n.sv
// Directed vector bench for shift_univ_reg_n at N=8.
module tb_shift_univ_reg_n;
  import shift_univ_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  shift_univ_if #(.N(N), .CW(CW)) bus ();

  shift_univ_reg_n #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic       en;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[16];

  task automatic drive(input logic [2:0] m, input logic [7:0] dd, input logic sl,
                       input logic sr, input logic e, input logic st, input logic [3:0] c);
    bus.mode  = m;
    bus.d     = dd;
    bus.sil   = sl;
    bus.sir   = sr;
    bus.en    = e;
    bus.start = st;
    bus.cnt   = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    n_vec++;
    if (bus.q !== eq || bus.busy !== eb || bus.done !== ed ||
        bus.sor !== eq[0] || bus.sol !== eq[7]) begin
      n_err++;
      $display("FAIL %s: got q=%h busy=%b done=%b sor=%b sol=%b, want q=%h busy=%b done=%b sor=%b sol=%b",
               name, bus.q, bus.busy, bus.done, bus.sor, bus.sol, eq, eb, ed, eq[0], eq[7]);
    end
  endtask

  initial begin
    logic [7:0] model;

    // mode, d, sil, sir, en, start, cnt, expected q, busy, done
    vecs[0]  = '{MODE_LOAD, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{MODE_SHR,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'hD2, 1'b0, 1'b0};
    vecs[2]  = '{MODE_SHL,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0};
    vecs[4]  = '{MODE_ROL,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h03, 1'b0, 1'b0};
    vecs[5]  = '{MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0};
    vecs[6]  = '{MODE_ROR,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'hC0, 1'b0, 1'b0};
    vecs[7]  = '{MODE_RSVD, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'hC0, 1'b0, 1'b0};
    vecs[8]  = '{MODE_HOLD, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'hC0, 1'b0, 1'b0};
    vecs[9]  = '{MODE_ASR,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'hE0, 1'b0, 1'b0};
    vecs[10] = '{MODE_SHR,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h70, 1'b0, 1'b0};
    vecs[11] = '{MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h70, 1'b0, 1'b0};
    vecs[12] = '{MODE_SHR,  8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 8'h70, 1'b0, 1'b1};
    vecs[13] = '{MODE_LOAD, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 8'h3C, 1'b0, 1'b1};
    vecs[14] = '{MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0};
    vecs[15] = '{MODE_SHL,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h78, 1'b0, 1'b0};

    // Reset overrides an enabled LOAD.
    rst = 1'b1;
    drive(MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    step();
    check("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].mode, vecs[i].d, vecs[i].sil, vecs[i].sir, vecs[i].en, vecs[i].start, vecs[i].cnt);
      step();
      check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed);
    end

    // ASR burst of 3 from 0x80, mode switched to LOAD while running.
    drive(MODE_LOAD, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); step();
    drive(MODE_ASR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3); step();
    check("asr_accept", 8'h80, 1'b1, 1'b0);
    drive(MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); step();
    check("asr_1", 8'hC0, 1'b1, 1'b0);
    step(); check("asr_2", 8'hE0, 1'b1, 1'b0);
    step(); check("asr_3", 8'hF0, 1'b0, 1'b1);
    drive(MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); step();
    check("asr_after", 8'hF0, 1'b0, 1'b0);

    // SHR burst of 4 with sil=1, stalled two cycles; a start mid-run is dropped.
    drive(MODE_LOAD, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0); step();
    drive(MODE_SHR, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4); step();
    check("shr_accept", 8'h00, 1'b1, 1'b0);
    drive(MODE_HOLD, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0); step();
    check("shr_1", 8'h80, 1'b1, 1'b0);
    drive(MODE_SHL, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1); step();
    check("shr_2", 8'hC0, 1'b1, 1'b0);
    drive(MODE_HOLD, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); step();
    check("shr_stall1", 8'hC0, 1'b1, 1'b0);
    step(); check("shr_stall2", 8'hC0, 1'b1, 1'b0);
    bus.en = 1'b1; step();
    check("shr_3", 8'hE0, 1'b1, 1'b0);
    step(); check("shr_4", 8'hF0, 1'b0, 1'b1);
    step(); check("shr_after", 8'hF0, 1'b0, 1'b0);

    // Reset on the second RUN cycle of a ROL burst of 5: no done.
    drive(MODE_LOAD, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); step();
    drive(MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5); step();
    check("rol_accept", 8'h01, 1'b1, 1'b0);
    bus.start = 1'b0; step();
    check("rol_1", 8'h02, 1'b1, 1'b0);
    rst = 1'b1; step();
    check("rol_reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; drive(MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); step();
    check("rol_no_done", 8'h00, 1'b0, 1'b0);
    drive(MODE_LOAD, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); step();
    drive(MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2); step();
    check("restart_accept", 8'h03, 1'b1, 1'b0);
    bus.start = 1'b0; step();
    check("restart_1", 8'h06, 1'b1, 1'b0);
    step(); check("restart_2", 8'h0C, 1'b0, 1'b1);

    // ROR burst of 9 from 0x01 wraps past N.
    drive(MODE_LOAD, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); step();
    drive(MODE_ROR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9); step();
    check("ror9_accept", 8'h01, 1'b1, 1'b0);
    bus.start = 1'b0;
    model = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      model = {model[0], model[7:1]};
      step();
      check($sformatf("ror9_%0d", k), model, 1'b1, 1'b0);
    end
    step();
    check("ror9_final", 8'h80, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
